riscv_top: RTL and testbench
============================

Name: riscv_top

Overview:
- Top level of a multicycle RV32I-subset processor. One unified word memory holds both instructions and data.
- Contains the PC and instruction register, a 32x32 register file, the immediate generator, the ALU, and a control FSM.
- Executes one instruction every 3–5 clocks. No external I/O beyond clock and reset; state is observed hierarchically.

Parameters:
- MEM_WORDS, 256, depth of the unified memory in 32-bit words.
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.

Behaviour:
- Reset asserted: FSM forced to FETCH, PC=RESET_PC, IR=0.
- Register file and memory contents are NOT cleared, so a bench can preload them. x0 always reads 0 and writes to it are ignored.
- While reset is held, the FSM stays in FETCH. The first rising edge after release executes FETCH.
- Memory: word addressed by addr[31:2], modulo MEM_WORDS. Combinational read, synchronous write.
- FSM state is 6-bit, kept in a shared enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BRANCHIFEQ.
- FETCH: IR <= M[PC]; OLDPC <= PC; PC <= PC+4; next state DECODE.
- DECODE: read rs1/rs2 into A/B registers. imm_ext is combinational from IR using RISC-V I/S/B/J formats, sign-extended to 32 bits. Transitions by opcode:
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 0000011 / 0100011 -> MEMADR
  - 1101111 -> JAL
  - 1100011 -> BRANCHIFEQ
  - anything else -> FETCH
- EXECUTER: ALU(A,B) per funct3/funct7 (add, sub, and, or, xor, slt, sll, srl, sra) -> ALUWB.
- EXECUTEI: ALU(A,imm) with the same ops -> ALUWB.
- ALUWB: rd <= ALU result; PC unchanged -> FETCH.
- MEMADR: address = A+imm. Next state MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: latch data -> MEMWB. MEMWB: rd <= data -> FETCH.
- MEMWRITE: M[addr] <= B -> FETCH.
- JAL: rd <= PC (already PC+4); PC <= OLDPC+imm -> FETCH.
- BRANCHIFEQ:
  - ALU computes A−B; zero flag = (result==0).
  - pc_src = 2'b11 (BRANCH) if zero, else 2'b00 (+4).
  - On the edge: BRANCH loads PC <= PC+imm, where PC is the already-incremented value. +4 loads PC <= PC+4.
  - Next state FETCH.
- pc_src encoding: 00 = PC+4, 01 = ALU result, 10 = reserved, 11 = PC+imm. It is decoded combinationally from the state and is 00 in every state except FETCH/BRANCHIFEQ/JAL.
- The zero flag is a combinational ALU output. It affects the PC only in BRANCHIFEQ; a zero result from an R/I op never redirects the PC.
- Arithmetic is 32-bit wrap-around (e.g. 4−12 = 32'hFFFFFFF8).
- Reset asserted mid-instruction aborts the instruction immediately; no register or memory write occurs.

Decomposition:
- Shared package holds:
  - the state enum, 6-bit logic;
  - opcode constants;
  - the ALU-op enum;
  - the pc_src constants PC_PLUS4 / PC_ALU / PC_BRANCH.
- control_fsm is the one natural sub-module: state register, next-state logic, and decoded control outputs (pc_src, reg_write, mem_write, alu_src, alu_op).
- Datapath, ALU, register file and memory stay in riscv_top.

Test Plan:
- Taken branch: preload M[0]=32'hFE420AE3 (beq x4,x4,-12), x4=42; release reset.
  - FETCH, then DECODE with PC=4 and imm=32'hFFFFFFF4.
  - BRANCHIFEQ with ALU a=b=42, zero=1, pc_src=2'b11, PC=4.
  - Next FETCH has PC=32'hFFFFFFF8.
- Not-taken branch: M[0]=beq x1,x2,+16, x1=42, x2=43.
  - DECODE with imm=32'h10.
  - BRANCHIFEQ with a=42, b=43, zero=0, pc_src=0.
  - Next FETCH has PC=8.
- Zero-result R-type: M[0]=sub x1,x1,x1, x1=1.
  - DECODE, then EXECUTER with zero=1, then ALUWB with PC=4, x1=0.
- Load/store: M[0]=sw x2,8(x0), M[1]=lw x3,8(x0), x2=32'hDEADBEEF.
  - M[2]=32'hDEADBEEF and x3=32'hDEADBEEF after MEMWB.
  - PC=8 at the following FETCH.
- JAL: M[0]=jal x1,+16.
  - x1=4 and PC=16 at the next FETCH.
- Reset mid-instruction: assert reset during EXECUTER of add x5,x0,x0 with x5=7.
  - State goes to FETCH asynchronously, PC=0, x5 remains 7.

Source files
------------

// File: rtl/riscv_top_pkg.sv
// Shared types for the multicycle RV32I-subset core: FSM states, opcodes,
// ALU operations, PC/writeback source selects and decode helpers.
package riscv_top_pkg;

    typedef enum logic [5:0] {
        FETCH      = 6'd0,
        DECODE     = 6'd1,
        MEMADR     = 6'd2,
        MEMREAD    = 6'd3,
        MEMWB      = 6'd4,
        MEMWRITE   = 6'd5,
        EXECUTER   = 6'd6,
        EXECUTEI   = 6'd7,
        ALUWB      = 6'd8,
        JAL        = 6'd9,
        BRANCHIFEQ = 6'd10
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8
    } alu_op_t;

    // 2'b10 is reserved; the PC holds if it is ever selected.
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_ALU    = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    function automatic logic [31:0] imm_gen(input logic [31:0] ir);
        logic [31:0] imm;
        case (ir[6:0])
            OP_STORE:  imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BRANCH: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_JAL:    imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:   imm = {{20{ir[31]}}, ir[31:20]};
        endcase
        return imm;
    endfunction

    // funct7 bit 5 selects sub only for register ops; for shifts it picks sra in both forms.
    function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt, input logic is_r);
        alu_op_t op;
        case (funct3)
            3'b000:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv_top_control_fsm.sv
// Control FSM: state register, next-state sequencing by opcode and the
// combinationally decoded datapath controls for the current state.
module riscv_top_control_fsm
    import riscv_top_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    output state_t     o_state,
    output logic [1:0] o_pc_src,
    output logic       o_pc_write,
    output logic       o_reg_write,
    output logic       o_mem_write,
    output logic       o_alu_src_a,
    output logic       o_alu_src_b,
    output alu_op_t    o_alu_op,
    output logic [1:0] o_wb_sel
);

    state_t r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            case (r_state)
                FETCH:  r_state <= DECODE;
                DECODE: begin
                    case (i_opcode)
                        OP_R:      r_state <= EXECUTER;
                        OP_I:      r_state <= EXECUTEI;
                        OP_LOAD:   r_state <= MEMADR;
                        OP_STORE:  r_state <= MEMADR;
                        OP_JAL:    r_state <= JAL;
                        OP_BRANCH: r_state <= BRANCHIFEQ;
                        default:   r_state <= FETCH;
                    endcase
                end
                MEMADR:     r_state <= (i_opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD:    r_state <= MEMWB;
                EXECUTER:   r_state <= ALUWB;
                EXECUTEI:   r_state <= ALUWB;
                default:    r_state <= FETCH;
            endcase
        end
    end

    assign o_state = r_state;

    // alu_src_a: 0 = A register, 1 = OLDPC.  alu_src_b: 0 = B register, 1 = immediate.
    always_comb begin
        o_pc_src    = PC_PLUS4;
        o_pc_write  = 1'b0;
        o_reg_write = 1'b0;
        o_mem_write = 1'b0;
        o_alu_src_a = 1'b0;
        o_alu_src_b = 1'b0;
        o_alu_op    = ALU_ADD;
        o_wb_sel    = WB_ALU;
        case (r_state)
            FETCH:    o_pc_write = 1'b1;
            EXECUTER: o_alu_op = alu_decode(i_funct3, i_funct7b5, 1'b1);
            EXECUTEI: begin
                o_alu_src_b = 1'b1;
                o_alu_op    = alu_decode(i_funct3, i_funct7b5, 1'b0);
            end
            ALUWB:    o_reg_write = 1'b1;
            MEMADR:   o_alu_src_b = 1'b1;
            MEMWB: begin
                o_reg_write = 1'b1;
                o_wb_sel    = WB_MEM;
            end
            MEMWRITE: o_mem_write = 1'b1;
            JAL: begin
                o_pc_write  = 1'b1;
                o_pc_src    = PC_ALU;
                o_alu_src_a = 1'b1;
                o_alu_src_b = 1'b1;
                o_reg_write = 1'b1;
                o_wb_sel    = WB_PC;
            end
            BRANCHIFEQ: begin
                o_alu_op   = ALU_SUB;
                o_pc_write = 1'b1;
                o_pc_src   = i_zero ? PC_BRANCH : PC_PLUS4;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_top.sv
// Multicycle RV32I-subset core: PC/IR, register file, immediate generator,
// ALU and a unified instruction/data word memory around the control FSM.
module riscv_top
    import riscv_top_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] RESET_PC  = 32'h00000000
) (
    input logic clk,
    input logic reset
);

    // MEM_WORDS is expected to be a power of two so the index slice is the modulo.
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [31:0] r_mem  [MEM_WORDS];
    logic [31:0] r_regs [32];

    logic [31:0] r_pc;
    logic [31:0] r_oldpc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_alu_out;
    logic [31:0] r_mdr;

    state_t      w_state;
    logic [1:0]  w_pc_src;
    logic        w_pc_write;
    logic        w_reg_write;
    logic        w_mem_write;
    logic        w_alu_src_a;
    logic        w_alu_src_b;
    alu_op_t     w_alu_op;
    logic [1:0]  w_wb_sel;

    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_imm;
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;
    logic        w_zero;
    logic [31:0] w_mem_addr;
    logic [AW-1:0] w_mem_idx;
    logic [31:0] w_mem_rdata;
    logic [31:0] w_wb_data;
    logic [31:0] w_pc_next;
    logic        w_unused_addr_bits;

    riscv_top_control_fsm u_control_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_opcode    (r_ir[6:0]),
        .i_funct3    (r_ir[14:12]),
        .i_funct7b5  (r_ir[30]),
        .i_zero      (w_zero),
        .o_state     (w_state),
        .o_pc_src    (w_pc_src),
        .o_pc_write  (w_pc_write),
        .o_reg_write (w_reg_write),
        .o_mem_write (w_mem_write),
        .o_alu_src_a (w_alu_src_a),
        .o_alu_src_b (w_alu_src_b),
        .o_alu_op    (w_alu_op),
        .o_wb_sel    (w_wb_sel)
    );

    assign w_rs1      = r_ir[19:15];
    assign w_rs2      = r_ir[24:20];
    assign w_rd       = r_ir[11:7];
    assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
    assign w_imm      = imm_gen(r_ir);

    assign w_alu_a = w_alu_src_a ? r_oldpc : r_a;
    assign w_alu_b = w_alu_src_b ? w_imm : r_b;

    always_comb begin
        case (w_alu_op)
            ALU_SUB: w_alu_result = w_alu_a - w_alu_b;
            ALU_AND: w_alu_result = w_alu_a & w_alu_b;
            ALU_OR:  w_alu_result = w_alu_a | w_alu_b;
            ALU_XOR: w_alu_result = w_alu_a ^ w_alu_b;
            ALU_SLT: w_alu_result = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
            ALU_SLL: w_alu_result = w_alu_a << w_alu_b[4:0];
            ALU_SRL: w_alu_result = w_alu_a >> w_alu_b[4:0];
            ALU_SRA: w_alu_result = $unsigned($signed(w_alu_a) >>> w_alu_b[4:0]);
            default: w_alu_result = w_alu_a + w_alu_b;
        endcase
    end

    assign w_zero = (w_alu_result == 32'd0);

    // Single memory port: instruction fetch in FETCH, data address register otherwise.
    assign w_mem_addr         = (w_state == FETCH) ? r_pc : r_alu_out;
    assign w_mem_idx          = w_mem_addr[AW+1:2];
    assign w_mem_rdata        = r_mem[w_mem_idx];
    assign w_unused_addr_bits = ^{w_mem_addr[31:AW+2], w_mem_addr[1:0]};

    always_comb begin
        case (w_wb_sel)
            WB_MEM:  w_wb_data = r_mdr;
            WB_PC:   w_wb_data = r_pc;
            default: w_wb_data = r_alu_out;
        endcase
    end

    always_comb begin
        case (w_pc_src)
            PC_PLUS4:  w_pc_next = r_pc + 32'd4;
            PC_ALU:    w_pc_next = w_alu_result;
            PC_BRANCH: w_pc_next = r_pc + w_imm;
            default:   w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc      <= RESET_PC;
            r_oldpc   <= RESET_PC;
            r_ir      <= 32'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_alu_out <= 32'd0;
            r_mdr     <= 32'd0;
        end else begin
            if (w_state == FETCH) begin
                r_ir    <= w_mem_rdata;
                r_oldpc <= r_pc;
            end
            if (w_pc_write) begin
                r_pc <= w_pc_next;
            end
            if (w_state == DECODE) begin
                r_a <= w_rs1_data;
                r_b <= w_rs2_data;
            end
            if (w_state == MEMREAD) begin
                r_mdr <= w_mem_rdata;
            end
            r_alu_out <= w_alu_result;
        end
    end

    // Storage is never reset so contents survive reset; enables are low while reset holds FETCH.
    always_ff @(posedge clk) begin
        if (w_reg_write && (w_rd != 5'd0)) begin
            r_regs[w_rd] <= w_wb_data;
        end
        if (w_mem_write) begin
            r_mem[w_mem_idx] <= r_b;
        end
    end

endmodule

// File: tb/tb_riscv_top.sv
// Bench for riscv_top: preloads memory/registers hierarchically, runs single
// instructions from reset and compares architectural state with expectations.
module tb_riscv_top;
    import riscv_top_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    riscv_top #(.MEM_WORDS(256), .RESET_PC(32'h00000000)) dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // Reference ALU from the ISA definition of each funct3 operation.
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.r_mem[i] = 32'h0;
        for (int i = 0; i < 32; i++) dut.r_regs[i] = 32'h0;
    endtask

    task automatic go();
        reset = 1'b1;
    endtask

    task automatic wait_state(input state_t s, input int budget, input string name);
        int n;
        n = 0;
        while (dut.w_state != s && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(dut.w_state), 32'(s));
    endtask

    initial begin
        logic [2:0]  f3s [7];
        logic [2:0]  f3;
        logic        alt;
        logic [11:0] imm12;
        logic [12:0] imm13;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] instr;

        f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};

        vecs[0]  = '{"add",  enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5,        32'd7,        5'd3, 32'd12};
        vecs[1]  = '{"sub",  enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'd4,        32'd12,       5'd3, 32'hFFFFFFF8};
        vecs[2]  = '{"and",  enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd3), 32'h0000F0F0, 32'h0000FF00, 5'd3, 32'h0000F000};
        vecs[3]  = '{"or",   enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd3), 32'h0000F0F0, 32'h00000F0F, 5'd3, 32'h0000FFFF};
        vecs[4]  = '{"xor",  enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd3), 32'h0000FFFF, 32'h000000FF, 5'd3, 32'h0000FF00};
        vecs[5]  = '{"slt",  enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3), 32'hFFFFFFFF, 32'd1,        5'd3, 32'd1};
        vecs[6]  = '{"sll",  enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd3), 32'd1,        32'd31,       5'd3, 32'h80000000};
        vecs[7]  = '{"srl",  enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd3), 32'h80000000, 32'd4,        5'd3, 32'h08000000};
        vecs[8]  = '{"sra",  enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3), 32'h80000000, 32'd4,        5'd3, 32'hF8000000};
        vecs[9]  = '{"addi", enc_i(12'hFFF, 5'd1, 3'd0, 5'd3, 7'b0010011), 32'd0, 32'd0,       5'd3, 32'hFFFFFFFF};
        vecs[10] = '{"srai", enc_i(12'h401, 5'd1, 3'd5, 5'd3, 7'b0010011), 32'h80000000, 32'd0, 5'd3, 32'hC0000000};
        vecs[11] = '{"xori", enc_i(12'hFFF, 5'd1, 3'd4, 5'd3, 7'b0010011), 32'h0000FFFF, 32'd0, 5'd3, 32'hFFFF0000};
        vecs[12] = '{"x0wr", enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'd5,        32'd7,        5'd0, 32'd0};

        // Taken branch: beq x4,x4,-12 from address 0.
        hold_reset();
        dut.r_mem[0]  = 32'hFE420AE3;
        dut.r_regs[4] = 32'd42;
        check("rst_state", 32'(dut.w_state), 32'(FETCH));
        check("rst_pc", dut.r_pc, 32'h0);
        check("rst_ir", dut.r_ir, 32'h0);
        go();
        step();
        check("bt_dec_state", 32'(dut.w_state), 32'(DECODE));
        check("bt_dec_pc", dut.r_pc, 32'd4);
        check("bt_dec_imm", dut.w_imm, 32'hFFFFFFF4);
        step();
        check("bt_br_state", 32'(dut.w_state), 32'(BRANCHIFEQ));
        check("bt_br_a", dut.w_alu_a, 32'd42);
        check("bt_br_b", dut.w_alu_b, 32'd42);
        check("bt_br_zero", 32'(dut.w_zero), 32'd1);
        check("bt_br_pcsrc", 32'(dut.w_pc_src), 32'd3);
        check("bt_br_pc", dut.r_pc, 32'd4);
        step();
        check("bt_fetch_state", 32'(dut.w_state), 32'(FETCH));
        check("bt_fetch_pc", dut.r_pc, 32'hFFFFFFF8);

        // Not-taken branch: beq x1,x2,+16.
        hold_reset();
        dut.r_mem[0]  = enc_b(13'd16, 5'd2, 5'd1);
        dut.r_regs[1] = 32'd42;
        dut.r_regs[2] = 32'd43;
        go();
        step();
        check("bn_dec_imm", dut.w_imm, 32'h10);
        step();
        check("bn_br_state", 32'(dut.w_state), 32'(BRANCHIFEQ));
        check("bn_br_a", dut.w_alu_a, 32'd42);
        check("bn_br_b", dut.w_alu_b, 32'd43);
        check("bn_br_zero", 32'(dut.w_zero), 32'd0);
        check("bn_br_pcsrc", 32'(dut.w_pc_src), 32'd0);
        step();
        check("bn_fetch_pc", dut.r_pc, 32'd8);

        // Zero-result R-type must not redirect the PC.
        hold_reset();
        dut.r_mem[0]  = enc_r(7'h20, 5'd1, 5'd1, 3'd0, 5'd1);
        dut.r_regs[1] = 32'd1;
        go();
        step();
        check("zr_dec_state", 32'(dut.w_state), 32'(DECODE));
        step();
        check("zr_ex_state", 32'(dut.w_state), 32'(EXECUTER));
        check("zr_ex_zero", 32'(dut.w_zero), 32'd1);
        check("zr_ex_pcsrc", 32'(dut.w_pc_src), 32'd0);
        step();
        check("zr_wb_state", 32'(dut.w_state), 32'(ALUWB));
        check("zr_wb_pc", dut.r_pc, 32'd4);
        step();
        check("zr_x1", dut.r_regs[1], 32'd0);
        check("zr_fetch_pc", dut.r_pc, 32'd4);

        // Store then load through the unified memory.
        hold_reset();
        dut.r_mem[0]  = enc_s(12'd8, 5'd2, 5'd0);
        dut.r_mem[1]  = enc_i(12'd8, 5'd0, 3'b010, 5'd3, 7'b0000011);
        dut.r_regs[2] = 32'hDEADBEEF;
        go();
        wait_state(MEMWRITE, 6, "ls_memwrite_reached");
        step();
        check("ls_mem2", dut.r_mem[2], 32'hDEADBEEF);
        check("ls_sw_pc", dut.r_pc, 32'd4);
        wait_state(MEMWB, 8, "ls_memwb_reached");
        step();
        check("ls_x3", dut.r_regs[3], 32'hDEADBEEF);
        check("ls_lw_state", 32'(dut.w_state), 32'(FETCH));
        check("ls_lw_pc", dut.r_pc, 32'd8);

        // JAL: link register gets PC+4, target is instruction address + imm.
        hold_reset();
        dut.r_mem[0] = enc_j(21'd16, 5'd1);
        go();
        wait_state(JAL, 4, "jal_reached");
        step();
        check("jal_x1", dut.r_regs[1], 32'd4);
        check("jal_pc", dut.r_pc, 32'd16);
        check("jal_state", 32'(dut.w_state), 32'(FETCH));

        // Reset during EXECUTER aborts the add before its writeback.
        hold_reset();
        dut.r_mem[0]  = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd5);
        dut.r_regs[5] = 32'd7;
        go();
        wait_state(EXECUTER, 4, "mr_exec_reached");
        reset = 1'b0;
        #1;
        check("mr_state", 32'(dut.w_state), 32'(FETCH));
        check("mr_pc", dut.r_pc, 32'h0);
        step();
        step();
        check("mr_x5", dut.r_regs[5], 32'd7);
        check("mr_hold_state", 32'(dut.w_state), 32'(FETCH));

        // Directed ALU vector table.
        for (int i = 0; i < NV; i++) begin
            hold_reset();
            dut.r_mem[0]  = vecs[i].instr;
            dut.r_regs[1] = vecs[i].v1;
            dut.r_regs[2] = vecs[i].v2;
            go();
            wait_state(ALUWB, 6, {vecs[i].name, "_wb"});
            step();
            check({vecs[i].name, "_rd"}, dut.r_regs[vecs[i].rd], vecs[i].exp);
            check({vecs[i].name, "_pc"}, dut.r_pc, 32'd4);
        end

        // Random ALU ops and branches against the reference model.
        for (int t = 0; t < 60; t++) begin
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rd = 5'($urandom_range(3, 31));
            f3 = f3s[$urandom_range(0, 6)];
            hold_reset();
            dut.r_regs[rd] = 32'h5A5A5A5A;
            case ($urandom_range(0, 2))
                0: begin
                    alt   = (f3 == 3'd0 || f3 == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0;
                    instr = enc_r({1'b0, alt, 5'd0}, 5'd2, 5'd1, f3, rd);
                    exp_q.push_back(ref_alu(f3, alt, a, b));
                end
                1: begin
                    alt = 1'b0;
                    if (f3 == 3'd1) begin
                        imm12 = {7'd0, 5'($urandom_range(0, 31))};
                    end else if (f3 == 3'd5) begin
                        alt   = 1'($urandom_range(0, 1));
                        imm12 = {1'b0, alt, 5'd0, 5'($urandom_range(0, 31))};
                    end else begin
                        imm12 = 12'($urandom_range(0, 4095));
                    end
                    instr = enc_i(imm12, 5'd1, f3, rd, 7'b0010011);
                    exp_q.push_back(ref_alu(f3, alt, a, {{20{imm12[11]}}, imm12}));
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) b = a;
                    imm13 = 13'($urandom_range(0, 8191)) & 13'h1FFE;
                    instr = enc_b(imm13, 5'd2, 5'd1);
                    rd    = 5'd0;
                    exp_q.push_back((a == b) ? 32'd4 + {{19{imm13[12]}}, imm13} : 32'd8);
                end
            endcase
            dut.r_mem[0]  = instr;
            dut.r_regs[1] = a;
            dut.r_regs[2] = b;
            go();
            if (rd == 5'd0) begin
                wait_state(BRANCHIFEQ, 4, "rnd_br_reached");
                step();
                check("rnd_br_pc", dut.r_pc, exp_q.pop_front());
            end else begin
                wait_state(ALUWB, 5, "rnd_alu_reached");
                step();
                check("rnd_alu_rd", dut.r_regs[rd], exp_q.pop_front());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
